// File: rtl/uart_secded_pkg.sv
// rtl/uart_secded_pkg.sv - shared types and the Hamming(8,4) SEC-DED decoder for uart_rx_secded
package uart_secded_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    typedef enum logic {
        PAIR_HIGH = 1'b0,
        PAIR_LOW  = 1'b1
    } pair_state_t;

    localparam int CW_P1 = 0;
    localparam int CW_P2 = 1;
    localparam int CW_D0 = 2;
    localparam int CW_P4 = 3;
    localparam int CW_D1 = 4;
    localparam int CW_D2 = 5;
    localparam int CW_D3 = 6;
    localparam int CW_P  = 7;

    typedef struct packed {
        logic [7:0] cw;
        logic [3:0] nibble;
        logic       corrected;
        logic       dbl;
    } dec_t;

    function automatic dec_t hamming84_decode(input logic [7:0] cw);
        dec_t       r;
        logic [2:0] syn;
        logic [7:0] fix;
        syn[0] = cw[CW_P1] ^ cw[CW_D0] ^ cw[CW_D1] ^ cw[CW_D3];
        syn[1] = cw[CW_P2] ^ cw[CW_D0] ^ cw[CW_D2] ^ cw[CW_D3];
        syn[2] = cw[CW_P4] ^ cw[CW_D1] ^ cw[CW_D2] ^ cw[CW_D3];
        r   = '0;
        fix = cw;
        if (^cw) begin
            // Odd overall parity: one flipped bit; syndrome 0 means the parity bit itself.
            fix         = cw ^ ((syn == 3'd0) ? (8'd1 << CW_P) : (8'd1 << (syn - 3'd1)));
            r.corrected = 1'b1;
        end else if (syn != 3'd0) begin
            r.dbl = 1'b1;
        end
        r.cw     = fix;
        r.nibble = {fix[CW_D0], fix[CW_D1], fix[CW_D2], fix[CW_D3]};
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - baud tick generator and oversampling UART receive FSM
module uart_rx_core
    import uart_secded_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SAMPLE    = 16,
    parameter int BAUD_DVSR = 27
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    output logic                 o_s_tick,
    output logic                 o_done,
    output logic [DATA_SIZE-1:0] o_byte,
    output uart_state_t          o_state
);

    localparam int TW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
    localparam int SW = $clog2(SAMPLE);
    localparam int NW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DVSR - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(SAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(SAMPLE - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_SIZE - 1);

    logic [TW-1:0]        r_tcnt;
    uart_state_t          r_state, w_state_nx;
    logic [SW-1:0]        r_s, w_s_nx;
    logic [NW-1:0]        r_n, w_n_nx;
    logic [DATA_SIZE-1:0] r_b, w_b_nx;
    logic [DATA_SIZE-1:0] r_byte, w_byte_nx;
    logic                 r_done, w_done_nx;
    logic                 w_tick;

    assign w_tick   = (r_tcnt == TICK_LAST);
    assign o_s_tick = w_tick;
    assign o_done   = r_done;
    assign o_byte   = r_byte;
    assign o_state  = r_state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tcnt  <= '0;
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_byte  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_tcnt  <= w_tick ? '0 : r_tcnt + TW'(1);
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_n     <= w_n_nx;
            r_b     <= w_b_nx;
            r_byte  <= w_byte_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_n_nx     = r_n;
        w_b_nx     = r_b;
        w_byte_nx  = r_byte;
        w_done_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_rx) begin
                    w_state_nx = ST_START;
                    w_s_nx     = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == HALF_LAST) begin
                        // Mid-start-bit check rejects glitches shorter than half a bit.
                        if (!i_rx) begin
                            w_state_nx = ST_DATA;
                            w_s_nx     = '0;
                            w_n_nx     = '0;
                        end else begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_s_nx = r_s + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == FULL_LAST) begin
                        w_s_nx = '0;
                        w_b_nx = {i_rx, r_b[DATA_SIZE-1:1]};
                        if (r_n == BIT_LAST) w_state_nx = ST_STOP;
                        else                 w_n_nx     = r_n + NW'(1);
                    end else begin
                        w_s_nx = r_s + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == FULL_LAST) begin
                        w_state_nx = ST_IDLE;
                        if (i_rx) begin
                            w_byte_nx = r_b;
                            w_done_nx = 1'b1;
                        end
                    end else begin
                        w_s_nx = r_s + SW'(1);
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_secded.sv
// rtl/uart_rx_secded.sv - UART receiver with SEC-DED nibble decode, byte pairing and receive FIFO
module uart_rx_secded
    import uart_secded_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int SIZE_FIFO = 16,
    parameter int SYS_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int SAMPLE    = 16,
    parameter int BAUD_DVSR = (2 * SYS_FREQ + SAMPLE * BAUD_RATE) / (2 * SAMPLE * BAUD_RATE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 read_en,
    output logic                 s_tick,
    output logic [DATA_SIZE-1:0] out_rx,
    output logic [7:0]           rx_data_out,
    output logic [3:0]           sub_high_de1,
    output logic [3:0]           sub_low_de1,
    output logic                 h_ok,
    output logic                 l_ok,
    output logic                 join_ok,
    output logic [7:0]           real_output,
    output logic                 error_corrected,
    output logic                 double_error,
    output logic [7:0]           mstate,
    output logic [2:0]           RX_status_register,
    output logic [9:0]           dout,
    output logic                 wait_request,
    output logic                 wait_req,
    output logic                 read_latch
);

    localparam int AW = $clog2(SIZE_FIFO);

    uart_state_t w_state;
    logic        w_done;
    dec_t        w_dec;

    pair_state_t r_pair;
    logic [7:0]  r_rx_data_out, r_real_output;
    logic [3:0]  r_sub_high, r_sub_low;
    logic        r_h_ok, r_l_ok, r_join_ok;
    logic        r_hi_ec, r_hi_de, r_lo_ec, r_lo_de, r_ec, r_de;

    logic [9:0]  r_mem [SIZE_FIFO];
    logic [AW:0] r_wptr, r_rptr;
    logic [9:0]  r_dout;
    logic        r_read_latch, r_wait_req, r_overflow;
    logic        w_empty, w_full, w_push, w_pop;
    logic [9:0]  w_push_data;

    uart_rx_core #(
        .DATA_SIZE (DATA_SIZE),
        .SAMPLE    (SAMPLE),
        .BAUD_DVSR (BAUD_DVSR)
    ) u_core (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_rx     (rx),
        .o_s_tick (s_tick),
        .o_done   (w_done),
        .o_byte   (out_rx),
        .o_state  (w_state)
    );

    assign w_dec = hamming84_decode(out_rx[7:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pair        <= PAIR_HIGH;
            r_rx_data_out <= '0;
            r_real_output <= '0;
            r_sub_high    <= '0;
            r_sub_low     <= '0;
            r_h_ok        <= 1'b0;
            r_l_ok        <= 1'b0;
            r_join_ok     <= 1'b0;
            r_hi_ec       <= 1'b0;
            r_hi_de       <= 1'b0;
            r_lo_ec       <= 1'b0;
            r_lo_de       <= 1'b0;
            r_ec          <= 1'b0;
            r_de          <= 1'b0;
        end else begin
            r_l_ok    <= 1'b0;
            r_join_ok <= 1'b0;
            if (w_done) begin
                r_rx_data_out <= w_dec.cw;
                if (r_pair == PAIR_HIGH) begin
                    r_sub_high <= w_dec.nibble;
                    r_hi_ec    <= w_dec.corrected;
                    r_hi_de    <= w_dec.dbl;
                    r_h_ok     <= 1'b1;
                    r_pair     <= PAIR_LOW;
                end else begin
                    r_sub_low <= w_dec.nibble;
                    r_lo_ec   <= w_dec.corrected;
                    r_lo_de   <= w_dec.dbl;
                    r_l_ok    <= 1'b1;
                end
            end
            // Join one clock after the low nibble lands; the FIFO push happens on this same edge.
            if (r_l_ok) begin
                r_real_output <= {r_sub_high, r_sub_low};
                r_ec          <= r_hi_ec | r_lo_ec;
                r_de          <= r_hi_de | r_lo_de;
                r_join_ok     <= 1'b1;
                r_h_ok        <= 1'b0;
                r_pair        <= PAIR_HIGH;
            end
        end
    end

    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push      = r_l_ok;
    assign w_pop       = read_en && !w_empty;
    assign w_push_data = {r_hi_de | r_lo_de, r_hi_ec | r_lo_ec, r_sub_high, r_sub_low};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE_FIFO; i++) r_mem[i] <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_dout       <= '0;
            r_read_latch <= 1'b0;
            r_wait_req   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_wait_req   <= wait_request;
            r_read_latch <= w_pop;
            if (w_push) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_mem[r_wptr[AW-1:0]] <= w_push_data;
                    r_wptr                <= r_wptr + 1'b1;
                end
            end
            if (w_pop) begin
                r_dout <= r_mem[r_rptr[AW-1:0]];
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign rx_data_out        = r_rx_data_out;
    assign sub_high_de1       = r_sub_high;
    assign sub_low_de1        = r_sub_low;
    assign h_ok               = r_h_ok;
    assign l_ok               = r_l_ok;
    assign join_ok            = r_join_ok;
    assign real_output        = r_real_output;
    assign error_corrected    = r_ec;
    assign double_error       = r_de;
    assign mstate             = {5'b0, r_pair, w_state};
    assign RX_status_register = {w_full, r_overflow, !w_empty};
    assign dout               = r_dout;
    assign wait_request       = read_en && w_empty;
    assign wait_req           = r_wait_req;
    assign read_latch         = r_read_latch;

endmodule

// File: tb/tb_uart_rx_secded.sv
// tb/tb_uart_rx_secded.sv - scoreboard bench for uart_rx_secded: decode, pairing, FIFO, reset
`timescale 1ns/1ps
module tb_uart_rx_secded;

    localparam int SIZE_FIFO = 16;
    localparam int BIT       = 48;   // 16 ticks * 3 clocks with the overridden clock/baud

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] hi_fix;
        logic [7:0] lo_fix;
        logic [9:0] entry;
    } pair_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       read_en = 1'b0;
    logic       s_tick;
    logic [7:0] out_rx, rx_data_out, real_output, mstate;
    logic [3:0] sub_high_de1, sub_low_de1;
    logic       h_ok, l_ok, join_ok, error_corrected, double_error;
    logic [2:0] RX_status_register;
    logic [9:0] dout;
    logic       wait_request, wait_req, read_latch;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         mcount   = 0;
    bit         movf     = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] last_dout = '0;

    uart_rx_secded #(
        .DATA_SIZE (8),
        .SIZE_FIFO (SIZE_FIFO),
        .SYS_FREQ  (4000000),
        .BAUD_RATE (100000),
        .SAMPLE    (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .rx                 (rx),
        .read_en            (read_en),
        .s_tick             (s_tick),
        .out_rx             (out_rx),
        .rx_data_out        (rx_data_out),
        .sub_high_de1       (sub_high_de1),
        .sub_low_de1        (sub_low_de1),
        .h_ok               (h_ok),
        .l_ok               (l_ok),
        .join_ok            (join_ok),
        .real_output        (real_output),
        .error_corrected    (error_corrected),
        .double_error       (double_error),
        .mstate             (mstate),
        .RX_status_register (RX_status_register),
        .dout               (dout),
        .wait_request       (wait_request),
        .wait_req           (wait_req),
        .read_latch         (read_latch)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] c;
        c    = '0;
        c[2] = n[3];
        c[4] = n[2];
        c[5] = n[1];
        c[6] = n[0];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        c[7] = ^c[6:0];
        return c;
    endfunction

    function automatic void corrupt(input logic [3:0] nib, input int kind,
                                    output logic [7:0] raw, output logic [7:0] fix,
                                    output logic [3:0] got);
        int a, b;
        a   = int'($urandom_range(7));
        b   = (a + 1 + int'($urandom_range(6))) % 8;
        raw = enc(nib);
        fix = raw;
        got = nib;
        if (kind >= 1) raw[a] = ~raw[a];
        if (kind == 2) begin
            raw[b] = ~raw[b];
            fix    = raw;
            got    = {raw[2], raw[4], raw[5], raw[6]};
        end
    endfunction

    function automatic pair_t make_pair(input logic [3:0] nh, input logic [3:0] nl,
                                        input int kh, input int kl);
        pair_t      p;
        logic [3:0] gh, gl;
        corrupt(nh, kh, p.hi, p.hi_fix, gh);
        corrupt(nl, kl, p.lo, p.lo_fix, gl);
        p.entry = {(kh == 2) || (kl == 2), (kh == 1) || (kl == 1), gh, gl};
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        if (good_stop) begin
            rx = 1'b1;
            repeat (BIT + 8) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (32) @(negedge clk);
            rx = 1'b1;
            repeat (BIT + 48) @(negedge clk);
        end
    endtask

    task automatic run_pair(input pair_t p, input bit bad_between);
        bit seen_j, seen_l;
        if (mcount == SIZE_FIFO) movf = 1'b1;
        else begin
            exp_q.push_back(p.entry);
            mcount++;
        end
        send_byte(p.hi, 1'b1);
        n_checks++; if (h_ok !== 1'b1 || mstate !== 8'h04) $display("FAIL high_capture h_ok=%b mstate=%h required 1/04", h_ok, mstate); else n_pass++;
        n_checks++; if (sub_high_de1 !== p.entry[7:4]) $display("FAIL sub_high got %h required %h", sub_high_de1, p.entry[7:4]); else n_pass++;
        n_checks++; if (rx_data_out !== p.hi_fix) $display("FAIL rx_data_out_high got %h required %h", rx_data_out, p.hi_fix); else n_pass++;
        if (bad_between) begin
            send_byte(8'hA5, 1'b0);
            n_checks++; if (h_ok !== 1'b1 || mstate !== 8'h04 || out_rx !== p.hi) $display("FAIL framing_discard h_ok=%b mstate=%h out_rx=%h required 1/04/%h", h_ok, mstate, out_rx, p.hi); else n_pass++;
        end
        seen_j = 1'b0;
        seen_l = 1'b0;
        fork
            send_byte(p.lo, 1'b1);
            begin
                for (int i = 0; i < 700 && !seen_j; i++) begin
                    @(negedge clk);
                    if (l_ok === 1'b1) seen_l = 1'b1;
                    if (join_ok === 1'b1) seen_j = 1'b1;
                end
            end
        join
        n_checks++; if (!seen_j) $display("FAIL join_ok_timeout got none required pulse"); else n_pass++;
        n_checks++; if (!seen_l) $display("FAIL l_ok_pulse got none required pulse"); else n_pass++;
        n_checks++; if (real_output !== p.entry[7:0]) $display("FAIL real_output got %h required %h", real_output, p.entry[7:0]); else n_pass++;
        n_checks++; if ({double_error, error_corrected} !== p.entry[9:8]) $display("FAIL flags de/ec got %b%b required %b", double_error, error_corrected, p.entry[9:8]); else n_pass++;
        n_checks++; if (sub_low_de1 !== p.entry[3:0]) $display("FAIL sub_low got %h required %h", sub_low_de1, p.entry[3:0]); else n_pass++;
        n_checks++; if (rx_data_out !== p.lo_fix || out_rx !== p.lo) $display("FAIL low_cw rx_data_out=%h out_rx=%h required %h/%h", rx_data_out, out_rx, p.lo_fix, p.lo); else n_pass++;
        n_checks++; if (h_ok !== 1'b0 || mstate !== 8'h00) $display("FAIL after_join h_ok=%b mstate=%h required 0/00", h_ok, mstate); else n_pass++;
        n_checks++; if (RX_status_register !== {mcount == SIZE_FIFO, movf, mcount != 0}) $display("FAIL status got %b required %b", RX_status_register, {mcount == SIZE_FIFO, movf, mcount != 0}); else n_pass++;
    endtask

    task automatic do_read(input int n);
        bit         exp_w, popped;
        logic [9:0] e;
        for (int i = 0; i < n; i++) begin
            read_en = 1'b1;
            #1;
            exp_w  = (mcount == 0);
            popped = (mcount != 0);
            n_checks++; if (wait_request !== exp_w) $display("FAIL wait_request got %b required %b", wait_request, exp_w); else n_pass++;
            if (popped) mcount--;
            @(negedge clk);
            n_checks++; if (read_latch !== popped) $display("FAIL read_latch got %b required %b", read_latch, popped); else n_pass++;
            n_checks++; if (wait_req !== exp_w) $display("FAIL wait_req got %b required %b", wait_req, exp_w); else n_pass++;
            if (popped) e = exp_q.pop_front();
            else        e = last_dout;
            n_checks++; if (dout !== e) $display("FAIL dout got %h required %h", dout, e); else n_pass++;
            last_dout = e;
        end
        read_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({out_rx, rx_data_out, real_output, sub_high_de1, sub_low_de1} !== 32'h0) $display("FAIL reset_data got %h required 0", {out_rx, rx_data_out, real_output, sub_high_de1, sub_low_de1}); else n_pass++;
        n_checks++; if ({h_ok, l_ok, join_ok, error_corrected, double_error, s_tick} !== 6'b0) $display("FAIL reset_flags got %b required 0", {h_ok, l_ok, join_ok, error_corrected, double_error, s_tick}); else n_pass++;
        n_checks++; if ({mstate, RX_status_register} !== 11'h0) $display("FAIL reset_state got %h required 0", {mstate, RX_status_register}); else n_pass++;
        n_checks++; if ({dout, wait_request, wait_req, read_latch} !== 13'h0) $display("FAIL reset_fifo_out got %h required 0", {dout, wait_request, wait_req, read_latch}); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_baud();
        int ticks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_tick === 1'b1) ticks++;
        end
        n_checks++; if (ticks != 10) $display("FAIL s_tick_rate got %0d required 10 in 30 clk", ticks); else n_pass++;
    endtask

    task automatic test_plan_pairs();
        run_pair('{hi: 8'hEF, lo: 8'hDF, hi_fix: 8'hFF, lo_fix: 8'hFF, entry: 10'h1FF}, 1'b0);
        run_pair('{hi: 8'h68, lo: 8'h75, hi_fix: 8'h78, lo_fix: 8'h55, entry: 10'h17D}, 1'b0);
        run_pair('{hi: 8'hF3, lo: 8'hCF, hi_fix: 8'hF3, lo_fix: 8'hCF, entry: 10'h279}, 1'b0);
    endtask

    task automatic test_fifo_read();
        do_read(1);
        repeat (3) @(negedge clk);
        do_read(1);
        repeat (3) @(negedge clk);
        do_read(5);
        n_checks++; if (RX_status_register[0] !== 1'b0) $display("FAIL status_empty got %b required 0", RX_status_register[0]); else n_pass++;
    endtask

    task automatic test_clean();
        run_pair('{hi: 8'h78, lo: 8'h55, hi_fix: 8'h78, lo_fix: 8'h55, entry: 10'h07D}, 1'b0);
        do_read(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++)
            run_pair(make_pair(4'($urandom), 4'($urandom), int'($urandom_range(2)), int'($urandom_range(2))), 1'b0);
        do_read(4);
    endtask

    task automatic test_framing();
        run_pair(make_pair(4'hA, 4'h3, 0, 1), 1'b1);
        do_read(1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < SIZE_FIFO + 1; i++)
            run_pair(make_pair(4'(i), 4'(15 - i), 0, 0), 1'b0);
        n_checks++; if (RX_status_register !== 3'b111) $display("FAIL overflow_status got %b required 111", RX_status_register); else n_pass++;
        do_read(SIZE_FIFO + 1);
        n_checks++; if (RX_status_register !== 3'b010) $display("FAIL drained_status got %b required 010", RX_status_register); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        pair_t p;
        send_byte(8'h78, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT * 3) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({out_rx, rx_data_out, real_output, sub_high_de1, sub_low_de1} !== 32'h0) $display("FAIL midreset_data got %h required 0", {out_rx, rx_data_out, real_output, sub_high_de1, sub_low_de1}); else n_pass++;
        n_checks++; if ({h_ok, l_ok, join_ok, error_corrected, double_error, mstate, RX_status_register, dout, read_latch, wait_req} !== 27'h0) $display("FAIL midreset_ctrl got %h required 0", {h_ok, l_ok, join_ok, error_corrected, double_error, mstate, RX_status_register, dout, read_latch, wait_req}); else n_pass++;
        reset = 1'b0;
        exp_q.delete();
        mcount    = 0;
        movf      = 1'b0;
        last_dout = '0;
        repeat (BIT) @(negedge clk);
        p = make_pair(4'h6, 4'hC, 1, 2);
        run_pair(p, 1'b0);
        do_read(1);
    endtask

    initial begin
        test_reset();
        test_baud();
        test_plan_pairs();
        test_fifo_read();
        test_clean();
        test_random();
        test_framing();
        test_overflow();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_secded.md
Name: uart_rx_secded

Overview:
UART receiver with SEC-DED Hamming(8,4) decoding. Each data byte arrives as two codewords: high nibble first, then low nibble. The block corrects single-bit errors, flags double-bit errors, joins the two nibbles into one byte, and pushes the byte plus its error flags into a receive FIFO. It sits between the serial rx pin and a bus-side reader that uses a read_en/wait_request handshake.

Parameters:
- DATA_SIZE, 8: UART frame data bits; also the width of the joined byte.
- SIZE_FIFO, 16: FIFO depth in entries; power of two.
- SYS_FREQ, 50000000: clk frequency in Hz.
- BAUD_RATE, 115200: serial bit rate.
- SAMPLE, 16: oversampling ticks per bit.
- BAUD_DVSR, (2*SYS_FREQ + SAMPLE*BAUD_RATE)/(2*SAMPLE*BAUD_RATE): clocks per s_tick, i.e. the rounded divider; 27 at the defaults.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input; idles high.
- read_en  in  1  FIFO pop request, level-sensitive.
- s_tick  out  1  one-clk pulse every BAUD_DVSR clocks.
- out_rx  out  8  last raw UART byte received.
- rx_data_out  out  8  last codeword after correction.
- sub_high_de1  out  4  decoded high nibble.
- sub_low_de1  out  4  decoded low nibble.
- h_ok  out  1  high nibble captured, waiting for the low nibble.
- l_ok  out  1  low nibble captured (one-clk pulse).
- join_ok  out  1  one-clk pulse when a pair is joined and pushed.
- real_output  out  8  last joined byte.
- error_corrected  out  1  last pair had at least one corrected single error.
- double_error  out  1  last pair had a double error in either codeword.
- mstate  out  8  debug state: [1:0] UART FSM, [2] pair state, [7:3]=0.
- RX_status_register  out  3  [0] FIFO not empty; [1] overflow (sticky); [2] FIFO full.
- dout  out  10  popped entry {double_error, error_corrected, byte}.
- wait_request  out  1  combinational: read_en & FIFO empty.
- wait_req  out  1  wait_request registered one clk.
- read_latch  out  1  one-clk pulse in the cycle dout holds a newly popped entry.

Behaviour:
Reset:
- Every output and register goes to 0, except mstate[1:0]=IDLE (also 0).
- FIFO is emptied and the pair state returns to "expect high".

Baud generator:
- Counter 0..BAUD_DVSR-1; s_tick fires when the counter reaches BAUD_DVSR-1.

UART receive FSM (IDLE=0, START=1, DATA=2, STOP=3):
- IDLE: rx low moves to START.
- START: after 7 ticks, rx still low moves to DATA; rx high is a glitch and returns to IDLE.
- DATA: sample every 16 ticks, LSB first, 8 bits.
- STOP: after 16 ticks, rx=1 accepts the byte, sets out_rx, and raises byte-done for one clk.
- STOP with rx=0 is a framing error: the byte is discarded and the pair state is unchanged.

Codeword layout (cw[7:0]):
- cw0=p1, cw1=p2, cw2=d0, cw3=p4, cw4=d1, cw5=d2, cw6=d3, cw7=P (overall even parity).
- Nibble = {d0,d1,d2,d3}, so nibble[3]=cw2.

Decode (combinational on byte-done, registered with it):
- s1 = cw0^cw2^cw4^cw6; s2 = cw1^cw2^cw5^cw6; s4 = cw3^cw4^cw5^cw6; syn = {s4,s2,s1}; par = ^cw.
- syn=0, par=0: no error.
- par=1: single error. If syn≠0, flip bit position syn (cw[syn-1]); if syn=0, P itself is in error. Either way, mark corrected.
- syn≠0, par=0: double error; the data bits are passed through uncorrected.

Pair assembly:
- Expect-high state: a decoded nibble goes to sub_high_de1; set h_ok; move to expect-low.
- Expect-low state: a decoded nibble goes to sub_low_de1; pulse l_ok.
- On the next clk: real_output = {high, low}; update both flags (OR of the two codewords); pulse join_ok; clear h_ok; push {de, ec, byte}; return to expect-high.
- There is no inter-byte timeout.

FIFO:
- Push while full drops the entry and sets overflow.
- read_en with FIFO not empty pops; dout and read_latch update on the next clk.
- read_en with FIFO empty does nothing; dout holds its value.
- Push and pop in the same clk are both performed.
- A reader holding read_en high pops one entry per clk until empty.

Decomposition:
- Package uart_secded_pkg: UART FSM state enum; codeword bit-index constants; function hamming84_decode(cw) returning {nibble, corrected, double}.
- One natural sub-module: uart_rx_core (baud tick generator plus UART FSM).
- Decode, pair assembly and the FIFO stay in the top level.

Test Plan:
- Bytes 0xEF then 0xDF (syndromes 5 and 6) -> join_ok; real_output=0xFF; error_corrected=1; double_error=0; FIFO entry 0x1FF.
- Bytes 0x68 then 0x75 -> rx_data_out 0x78 then 0x55; real_output=0x7D; entry 0x17D.
- Clean bytes 0x78 then 0x55 -> real_output=0x7D; both flags 0; entry 0x07D.
- Bytes 0xF3 then 0xCF (syndromes 7 and 3, even parity) -> double_error=1; real_output=0x79; entry 0x279.
- After the three pairs above, read_en high for 1 clk, 1 clk, then 5 clk -> dout 0x1FF, 0x17D, 0x279 in order, each with a read_latch pulse; wait_request high on reads once empty; RX_status_register[0] ends at 0.
- 17 pairs with no reads -> RX_status_register[2] then [1] set; reset asserted mid-frame -> all outputs 0 and the next frame decodes correctly.
